// File: rtl/nios_system_sysid_ext_if.sv
// ==== nios_system_sysid_ext_if : Avalon-MM slave bus bundle for the sysid block ====
// ==== Revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

interface nios_system_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/nios_system_sysid_ext.sv
// ==== nios_system_sysid_ext : sysid slave with uptime counter, scratch and control ====
// ==== Revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module nios_system_sysid_ext #(
  parameter logic [31:0] ID            = 32'h5AD1_F01C,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int          CNT_WIDTH     = 48,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  nios_system_sysid_ext_if.slave bus
);

  // CNT_WIDTH must stay within 33..64 so the high word is 1..32 bits wide.
  localparam int HI_WIDTH = CNT_WIDTH - 32;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_CNT_LO  = 3'd2;
  localparam logic [2:0] ADDR_CNT_HI  = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  logic [CNT_WIDTH-1:0] cnt;
  logic [HI_WIDTH-1:0]  hi_latch;
  logic [31:0]          scratch;
  logic                 freeze;
  logic [31:0]          readdata;
  logic                 readdatavalid;

  logic [31:0] hi_ext;
  logic [31:0] rd_mux;
  logic        ctrl_wr;
  logic        clear;
  logic        lo_rd;

  assign ctrl_wr = bus.write && (bus.address == ADDR_CTRL);
  assign clear   = ctrl_wr && bus.writedata[1];
  assign lo_rd   = bus.read && (bus.address == ADDR_CNT_LO);

  // Read mux sees pre-edge state, so a simultaneous write returns the old value.
  always_comb begin
    hi_ext                 = '0;
    hi_ext[HI_WIDTH-1:0]   = hi_latch;
    rd_mux                 = '0;
    case (bus.address)
      ADDR_ID:      rd_mux = ID;
      ADDR_TS:      rd_mux = TIMESTAMP;
      ADDR_CNT_LO:  rd_mux = cnt[31:0];
      ADDR_CNT_HI:  rd_mux = hi_ext;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_CTRL:    rd_mux = {31'd0, freeze};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // The high word is captured with every low-word read so a later CNT_HI read is coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_latch <= '0;
    end else if (lo_rd) begin
      hi_latch <= cnt[CNT_WIDTH-1:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
      freeze  <= 1'b0;
    end else if (bus.write) begin
      if (bus.address == ADDR_SCRATCH) begin
        scratch <= bus.writedata;
      end
      if (ctrl_wr) begin
        freeze <= bus.writedata[0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= bus.read;
      if (bus.read) begin
        readdata <= rd_mux;
      end
    end
  end

  assign bus.readdata      = readdata;
  assign bus.readdatavalid = readdatavalid;

endmodule

`default_nettype wire

// File: tb/tb_nios_system_sysid_ext.sv
// ==== tb_nios_system_sysid_ext : self-checking bench for nios_system_sysid_ext ====
// ==== Revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module tb_nios_system_sysid_ext;

  localparam logic [31:0] ID_V    = 32'h5AD1_F01C;
  localparam logic [31:0] TS_V    = 32'h6543_2107;
  localparam logic [31:0] SRST_V  = 32'hA5A5_0001;
  localparam int          CW      = 48;
  localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  nios_system_sysid_ext_if bus();

  nios_system_sysid_ext #(
    .ID(ID_V), .TIMESTAMP(TS_V), .CNT_WIDTH(CW), .SCRATCH_RESET(SRST_V)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register state, updated once per clock.
  longint unsigned m_cnt;
  longint unsigned m_hi;
  logic [31:0]     m_scratch;
  logic            m_freeze;
  logic            preload = 1'b0;
  longint unsigned preload_val = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_hi <= 0; m_scratch <= SRST_V; m_freeze <= 1'b0;
    end else begin
      if (bus.write && bus.address == 3'd4) m_scratch <= bus.writedata;
      if (bus.write && bus.address == 3'd5) m_freeze <= bus.writedata[0];
      if (bus.write && bus.address == 3'd5 && bus.writedata[1]) m_cnt <= 0;
      else if (preload) m_cnt <= preload_val;
      else if (!m_freeze) m_cnt <= (m_cnt + 1) & MASK;
      if (bus.read && bus.address == 3'd2) m_hi <= m_cnt / (64'd1 << 32);
    end
  end

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return ID_V;
      3'd1: return TS_V;
      3'd2: return m_cnt[31:0];
      3'd3: return m_hi[31:0];
      3'd4: return m_scratch;
      3'd5: return {31'd0, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  // Bus primitives: each starts and ends at a falling edge.
  task automatic rd1(input logic [2:0] a, output logic [31:0] d, output logic v);
    bus.address = a; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    d = bus.readdata; v = bus.readdatavalid;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    bus.address = a; bus.writedata = wd; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] wd,
                    output logic [31:0] d, output logic v);
    bus.address = a; bus.writedata = wd; bus.write = 1'b1; bus.read = 1'b1;
    @(negedge clock);
    bus.write = 1'b0; bus.read = 1'b0;
    d = bus.readdata; v = bus.readdatavalid;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [2:0]  addrs [5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6};
    logic [31:0] exps  [5] = '{ID_V, TS_V, SRST_V, 32'd0, 32'd0};
    logic [31:0] d;
    logic v;
    idle(2);
    n_checks++;
    if (bus.readdata !== 32'd0 || bus.readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b expected data=0 valid=0",
               bus.readdata, bus.readdatavalid);
    end
    reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      rd1(addrs[i], d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exps[i]) begin
        n_fail++;
        $display("FAIL reset_read addr%0d: got data=%h valid=%b expected data=%h valid=1",
                 addrs[i], d, v, exps[i]);
      end
      idle(1);
      n_checks++;
      if (bus.readdatavalid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_width addr%0d: got valid=%b expected 0", addrs[i], bus.readdatavalid);
      end
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d, r;
    logic v;
    wr(3'd4, 32'hDEADBEEF);
    rd1(3'd4, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL scratch_rw: got %h valid=%b expected deadbeef", d, v);
    end
    r = $urandom;
    wr(3'd4, r);
    rd1(3'd4, d, v);
    n_checks++;
    if (d !== r) begin
      n_fail++;
      $display("FAIL scratch_rand: got %h expected %h", d, r);
    end
    wr(3'd0, $urandom);
    wr(3'd1, $urandom);
    rd1(3'd0, d, v);
    n_checks++;
    if (d !== ID_V) begin
      n_fail++;
      $display("FAIL id_ro: got %h expected %h", d, ID_V);
    end
    rd1(3'd1, d, v);
    n_checks++;
    if (d !== TS_V) begin
      n_fail++;
      $display("FAIL ts_ro: got %h expected %h", d, TS_V);
    end
  endtask

  task automatic test_counter_rate();
    logic [31:0] d1, d2;
    logic v;
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    rd1(3'd2, d1, v);
    n_checks++;
    if (v !== 1'b1 || d1 !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_after_reset: got %h valid=%b expected 0", d1, v);
    end
    idle(5);
    rd1(3'd2, d2, v);
    n_checks++;
    if (d2 - d1 !== 32'd6) begin
      n_fail++;
      $display("FAIL cnt_rate: got delta %0d expected 6", d2 - d1);
    end
  endtask

  task automatic test_carry();
    logic [47:0] pv;
    logic [31:0] lo, hi, want_lo, want_hi;
    longint unsigned full;
    logic v;
    for (int k = 0; k < 4; k++) begin
      wr(3'd5, 32'd1);
      pv = 48'h0000_FFFF_FFFF - 48'($urandom_range(0, 2));
      force dut.cnt = pv;
      preload = 1'b1; preload_val = 64'(pv);
      idle(1);
      release dut.cnt;
      preload = 1'b0;
      wr(3'd5, 32'd0);
      idle(k);
      rd1(3'd2, lo, v);
      rd1(3'd3, hi, v);
      full    = 64'(pv) + longint'(k);
      want_lo = full[31:0];
      want_hi = {16'd0, full[47:32]};
      n_checks++;
      if (lo !== want_lo || hi !== want_hi) begin
        n_fail++;
        $display("FAIL carry_value k=%0d: got {%h,%h} expected {%h,%h}", k, hi, lo, want_hi, want_lo);
      end
      n_checks++;
      if (!((hi == 32'd0 && lo >= 32'hFFFF_FFF0) || (hi == 32'd1 && lo < 32'h10))) begin
        n_fail++;
        $display("FAIL carry_coherent k=%0d: got {%h,%h} expected a coherent pair", k, hi, lo);
      end
    end
  endtask

  task automatic test_freeze();
    logic [31:0] d1, d2;
    logic v;
    wr(3'd5, 32'd1);
    rd1(3'd2, d1, v);
    idle(9);
    rd1(3'd2, d2, v);
    n_checks++;
    if (d1 !== d2) begin
      n_fail++;
      $display("FAIL freeze_hold: got %h then %h expected equal", d1, d2);
    end
    wr(3'd5, 32'd3);
    rd1(3'd5, d1, v);
    n_checks++;
    if (d1 !== 32'd1) begin
      n_fail++;
      $display("FAIL ctrl_readback: got %h expected 1", d1);
    end
    rd1(3'd2, d1, v);
    n_checks++;
    if (d1 !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_frozen: got %h expected 0", d1);
    end
    wr(3'd5, 32'd0);
    idle(3);
    rd1(3'd2, d1, v);
    n_checks++;
    if (d1 !== 32'd3) begin
      n_fail++;
      $display("FAIL resume_count: got %h expected 3", d1);
    end
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] d, old, nv;
    logic v;
    old = model_read(3'd4);
    nv  = $urandom;
    rw(3'd4, nv, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== old) begin
      n_fail++;
      $display("FAIL rw_scratch_old: got %h valid=%b expected %h", d, v, old);
    end
    rd1(3'd4, d, v);
    n_checks++;
    if (d !== nv) begin
      n_fail++;
      $display("FAIL rw_scratch_new: got %h expected %h", d, nv);
    end
    rw(3'd5, 32'd1, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL rw_ctrl_old: got %h expected 0", d);
    end
    wr(3'd5, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  a;
    logic [31:0] d, e;
    logic v;
    for (int i = 0; i < 8; i++) begin
      a = 3'($urandom_range(0, 7));
      e = model_read(a);
      rd1(a, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] addr%0d: got %h valid=%b expected %h valid=1", i, a, d, v, e);
      end
    end
    idle(1);
    n_checks++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: got valid=%b expected 0", bus.readdatavalid);
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d, e, wd;
    logic v;
    for (int i = 0; i < 60; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd5) wd = {30'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0)};
      e  = model_read(a);
      case ($urandom_range(0, 3))
        0: begin
          rd1(a, d, v);
          n_checks++;
          if (v !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL rand_read[%0d] addr%0d: got %h valid=%b expected %h", i, a, d, v, e);
          end
        end
        1: wr(a, wd);
        2: begin
          rw(a, wd, d, v);
          n_checks++;
          if (v !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL rand_rw[%0d] addr%0d: got %h valid=%b expected %h", i, a, d, v, e);
          end
        end
        default: idle($urandom_range(1, 3));
      endcase
    end
    wr(3'd5, 32'd0);
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    logic v;
    logic seen;
    bus.address = 3'd2; bus.read = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock);
    bus.read = 1'b0;
    seen = bus.readdatavalid;
    idle(1);
    seen = seen | bus.readdatavalid;
    reset_n = 1'b1;
    idle(1);
    seen = seen | bus.readdatavalid;
    n_checks++;
    if (seen !== 1'b0 || bus.readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL inflight_discard: got valid_seen=%b data=%h expected 0 and 0", seen, bus.readdata);
    end
    rd1(3'd3, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hi: got %h expected 0", d);
    end
    rd1(3'd4, d, v);
    n_checks++;
    if (d !== SRST_V) begin
      n_fail++;
      $display("FAIL reset_scratch: got %h expected %h", d, SRST_V);
    end
    rd1(3'd5, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 0", d);
    end
    rd1(3'd2, d, v);
    n_checks++;
    if (d !== 32'd4) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h expected 4", d);
    end
  endtask

  initial begin
    bus.address = 3'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = 32'd0;
    test_reset();
    test_scratch();
    test_counter_rate();
    test_freeze();
    test_carry();
    test_read_write_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
